// File: rtl/i2s_pkg.sv
// ============================================================================
// i2s_pkg : shared defaults, stereo pair type and frame-rate helper for the
//           I2S transmitter.                                  Revision 1.0
// ============================================================================
`default_nettype none

package i2s_pkg;

   localparam int DEF_SAMPLE_WIDTH = 16;
   localparam int DEF_SLOT_WIDTH   = 32;
   localparam int DEF_BCLK_DIV     = 4;

   typedef struct packed {
      logic [DEF_SAMPLE_WIDTH-1:0] left;
      logic [DEF_SAMPLE_WIDTH-1:0] right;
   } stereo_pair_t;

   // One frame is 2 slots of SLOT bclk periods, each bclk period 2*DIV clocks.
   function automatic int unsigned fs_hz(input int unsigned clk_hz,
                                         input int unsigned bclk_div,
                                         input int unsigned slot_width);
      return clk_hz / (4 * bclk_div * slot_width);
   endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_tx_stereo_bclk_gen.sv
// ============================================================================
// i2s_bclk_gen : system-clock divider producing the registered bit clock and
//                a strobe marking the cycle before bclk falls.  Revision 1.0
// ============================================================================
`default_nettype none

module i2s_bclk_gen #(
   parameter int BCLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic bclk,
   output logic fall_evt
);

   localparam int                 CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [CNT_W-1:0]   TERM  = CNT_W'(BCLK_DIV - 1);

   logic [CNT_W-1:0] div_cnt;
   logic             terminal;

   assign terminal = (div_cnt == TERM);

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (terminal) begin
         div_cnt <= '0;
         bclk    <= ~bclk;
      end else begin
         div_cnt <= div_cnt + CNT_W'(1);
      end
   end

   // Registered consumers updating on this strobe change together with bclk's fall.
   assign fall_evt = terminal & bclk;

endmodule

`default_nettype wire

// File: rtl/i2s_tx_stereo.sv
// ============================================================================
// i2s_tx_stereo : stereo I2S transmitter with one-entry holding register.
//                 Optional macro I2S_TX_UNDERRUN_CNT_EN adds underrun_count.
//                                                             Revision 1.0
// ============================================================================
`default_nettype none

module i2s_tx_stereo
   import i2s_pkg::*;
#(
   parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
   parameter int SLOT_WIDTH   = DEF_SLOT_WIDTH,
   parameter int BCLK_DIV     = DEF_BCLK_DIV
) (
   input  logic                    clk_25mhz,
   input  logic                    reset,
   input  logic [SAMPLE_WIDTH-1:0] sample_left,
   input  logic [SAMPLE_WIDTH-1:0] sample_right,
   input  logic                    sample_valid,
   output logic                    sample_ready,
   output logic                    audio_bclk,
   output logic                    audio_lrclk,
   output logic                    audio_din,
   output logic                    underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
   ,
   output logic [15:0]             underrun_count
`endif
);

   localparam int               FRAME_BITS = 2 * SLOT_WIDTH;
   localparam int               K_W        = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
   localparam logic [K_W-1:0]   K_LAST     = K_W'(FRAME_BITS - 1);
   localparam logic [K_W-1:0]   K_SLOT     = K_W'(SLOT_WIDTH);

   logic                    fall_evt;
   logic [K_W-1:0]          k;
   logic [K_W-1:0]          k_next;
   logic                    wrap;
   logic                    left_phase;
   logic                    underrun_set;

   logic                    hold_full;
   logic [SAMPLE_WIDTH-1:0] hold_left;
   logic [SAMPLE_WIDTH-1:0] hold_right;
   logic [SLOT_WIDTH-1:0]   left_sh;
   logic [SLOT_WIDTH-1:0]   right_sh;

   function automatic logic [SLOT_WIDTH-1:0] to_slot(input logic [SAMPLE_WIDTH-1:0] s);
      return SLOT_WIDTH'(s) << (SLOT_WIDTH - SAMPLE_WIDTH);
   endfunction

   i2s_bclk_gen #(
      .BCLK_DIV (BCLK_DIV)
   ) u_bclk_gen (
      .clk      (clk_25mhz),
      .reset    (reset),
      .bclk     (audio_bclk),
      .fall_evt (fall_evt)
   );

   always_comb begin
      k_next       = (k == K_LAST) ? '0 : k + K_W'(1);
      wrap         = fall_evt && (k == K_LAST);
      // Left bits occupy k=1..SLOT; k=0 still belongs to the previous right slot.
      left_phase   = (k_next != '0) && (k_next <= K_SLOT);
      underrun_set = wrap && !hold_full;
   end

   assign sample_ready = !hold_full;

   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         k           <= '0;
         audio_lrclk <= 1'b0;
      end else if (fall_evt) begin
         k           <= k_next;
         audio_lrclk <= (k_next >= K_SLOT);
      end
   end

   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         hold_full  <= 1'b0;
         hold_left  <= '0;
         hold_right <= '0;
      end else if (sample_valid && !hold_full) begin
         hold_full  <= 1'b1;
         hold_left  <= sample_left;
         hold_right <= sample_right;
      end else if (wrap) begin
         hold_full  <= 1'b0;
      end
   end

   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         audio_din <= 1'b0;
         left_sh   <= '0;
         right_sh  <= '0;
         underrun  <= 1'b0;
      end else begin
         underrun <= underrun_set;
         if (fall_evt) begin
            if (left_phase) begin
               audio_din <= left_sh[SLOT_WIDTH-1];
               left_sh   <= left_sh << 1;
            end else begin
               audio_din <= right_sh[SLOT_WIDTH-1];
               right_sh  <= right_sh << 1;
            end
            // The load overrides the shift: the outgoing right LSB was captured above.
            if (wrap) begin
               if (hold_full) begin
                  left_sh  <= to_slot(hold_left);
                  right_sh <= to_slot(hold_right);
               end else begin
                  left_sh  <= '0;
                  right_sh <= '0;
               end
            end
         end
      end
   end

`ifdef I2S_TX_UNDERRUN_CNT_EN
   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         underrun_count <= '0;
      end else if (underrun_set && (underrun_count != 16'hFFFF)) begin
         underrun_count <= underrun_count + 16'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx_stereo.sv
// Directed bench for i2s_tx_stereo: default build plus a 24/24/1 instance.
`default_nettype none
`timescale 1ns/1ps

module tb_i2s_tx_stereo;
   import i2s_pkg::*;

   localparam int CLK_HZ = 25_000_000;

   logic clk = 1'b0;
   always #20 clk = ~clk;

   logic         reset;
   stereo_pair_t pair;
   logic         valid;
   logic         ready, bclk, lrclk, din, underrun;

   logic         reset24;
   logic [23:0]  l24, r24;
   logic         valid24;
   logic         ready24, bclk24, lrclk24, din24, underrun24;

`ifdef I2S_TX_UNDERRUN_CNT_EN
   logic [15:0]  ucount, ucount24;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int xfers  = 0;
   int unders = 0;
   int frame  = 512;

   i2s_tx_stereo dut (
      .clk_25mhz    (clk),
      .reset        (reset),
      .sample_left  (pair.left),
      .sample_right (pair.right),
      .sample_valid (valid),
      .sample_ready (ready),
      .audio_bclk   (bclk),
      .audio_lrclk  (lrclk),
      .audio_din    (din),
      .underrun     (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
      ,
      .underrun_count (ucount)
`endif
   );

   i2s_tx_stereo #(
      .SAMPLE_WIDTH (24),
      .SLOT_WIDTH   (24),
      .BCLK_DIV     (1)
   ) dut24 (
      .clk_25mhz    (clk),
      .reset        (reset24),
      .sample_left  (l24),
      .sample_right (r24),
      .sample_valid (valid24),
      .sample_ready (ready24),
      .audio_bclk   (bclk24),
      .audio_lrclk  (lrclk24),
      .audio_din    (din24),
      .underrun     (underrun24)
`ifdef I2S_TX_UNDERRUN_CNT_EN
      ,
      .underrun_count (ucount24)
`endif
   );

   initial begin
      #2ms;
      $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   // One main-DUT cycle; cyc is the cycle index since reset release.
   task automatic tick();
      if (valid && ready) xfers++;
      @(posedge clk);
      #1;
      cyc++;
      if (underrun) unders++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bclk !== 1'b0)     begin errors++; $display("FAIL reset_bclk got %b want 0", bclk); end
      checks++; if (lrclk !== 1'b0)    begin errors++; $display("FAIL reset_lrclk got %b want 0", lrclk); end
      checks++; if (din !== 1'b0)      begin errors++; $display("FAIL reset_din got %b want 0", din); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
      checks++; if (ready !== 1'b1)    begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
      checks++; if (ucount !== 16'd0)  begin errors++; $display("FAIL reset_ucount got %0d want 0", ucount); end
`endif
   endtask

   // Silent frames: din 0, underrun at every frame wrap, ready stays 1.
   task automatic test_idle(input int n);
      int   k;
      logic exp_u;
      for (int i = 0; i < n; i++) begin
         k     = (cyc % frame) / (2 * DEF_BCLK_DIV);
         exp_u = (cyc > 0) && (cyc % frame == 0);
         checks++; if (bclk !== 1'((cyc / DEF_BCLK_DIV) % 2)) begin errors++; $display("FAIL idle_bclk cyc=%0d got %b", cyc, bclk); end
         checks++; if (lrclk !== 1'(k >= 32)) begin errors++; $display("FAIL idle_lrclk cyc=%0d got %b want %b", cyc, lrclk, k >= 32); end
         checks++; if (din !== 1'b0) begin errors++; $display("FAIL idle_din cyc=%0d got %b want 0", cyc, din); end
         checks++; if (underrun !== exp_u) begin errors++; $display("FAIL idle_underrun cyc=%0d got %b want %b", cyc, underrun, exp_u); end
         checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready cyc=%0d got %b want 1", cyc, ready); end
         tick();
      end
   endtask

   // Checks serial data, word select and bit clock for n cycles of a frame
   // carrying slot words ls/rs; k=0 carries prev_rs LSB.
   task automatic check_frame(input logic [31:0] ls, input logic [31:0] rs,
                              input logic [31:0] prev_rs, input int n, input string tag);
      int   k;
      logic exp_din;
      for (int i = 0; i < n; i++) begin
         k = (cyc % frame) / (2 * DEF_BCLK_DIV);
         if (k == 0)       exp_din = prev_rs[0];
         else if (k <= 32) exp_din = ls[32 - k];
         else              exp_din = rs[64 - k];
         checks++; if (din !== exp_din) begin errors++; $display("FAIL %s_din cyc=%0d k=%0d got %b want %b", tag, cyc, k, din, exp_din); end
         checks++; if (lrclk !== 1'(k >= 32)) begin errors++; $display("FAIL %s_lrclk cyc=%0d got %b want %b", tag, cyc, lrclk, k >= 32); end
         checks++; if (bclk !== 1'((cyc / DEF_BCLK_DIV) % 2)) begin errors++; $display("FAIL %s_bclk cyc=%0d got %b", tag, cyc, bclk); end
         tick();
      end
   endtask

   task automatic test_single_push();
      pair  = '{left: 16'h8001, right: 16'h7FFE};
      valid = 1'b1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL push_ready_before got %b want 1", ready); end
      tick();
      valid = 1'b0;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL push_ready_held got %b want 0", ready); end
      while (cyc < 3 * frame) tick();
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL push_load_underrun got %b want 0", underrun); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL push_load_ready got %b want 1", ready); end
      check_frame(32'h8001_0000, 32'h7FFE_0000, 32'h0, frame, "push");
      checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL push_next_underrun got %b want 1", underrun); end
   endtask

   task automatic test_hold_valid();
      int x0, u0;
      x0    = xfers;
      u0    = unders;
      pair  = '{left: 16'h1234, right: 16'hABCD};
      valid = 1'b1;
      while (cyc < 5 * frame) tick();
      check_frame(32'h1234_0000, 32'hABCD_0000, 32'h0, frame, "hold");
      while (cyc < 8 * frame) tick();
      valid = 1'b0;
      checks++; if (xfers - x0 !== 4) begin errors++; $display("FAIL hold_transfers got %0d want 4", xfers - x0); end
      checks++; if (unders - u0 !== 0) begin errors++; $display("FAIL hold_underruns got %0d want 0", unders - u0); end
   endtask

   task automatic test_load_accept();
      check_frame(32'h1234_0000, 32'hABCD_0000, 32'hABCD_0000, frame - 1, "last");
      pair  = '{left: 16'h0F0F, right: 16'hF0F0};
      valid = 1'b1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL la_ready_before got %b want 1", ready); end
      tick();
      valid = 1'b0;
      checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL la_underrun got %b want 1", underrun); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL la_ready_after got %b want 0", ready); end
      check_frame(32'h0, 32'h0, 32'hABCD_0000, frame, "la_silent");
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL la_next_underrun got %b want 0", underrun); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL la_next_ready got %b want 1", ready); end
      check_frame(32'h0F0F_0000, 32'hF0F0_0000, 32'h0, frame, "la_pair");
      checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL la_final_underrun got %b want 1", underrun); end
   endtask

   task automatic test_reset_midframe();
      pair  = '{left: 16'hFFFF, right: 16'hFFFF};
      valid = 1'b1;
      tick();
      valid = 1'b0;
      while (cyc < 12 * frame) tick();
      pair  = '{left: 16'h1111, right: 16'h2222};
      valid = 1'b1;
      tick();
      valid = 1'b0;
      while (cyc < 12 * frame + 164) tick();
      checks++; if (bclk !== 1'b1) begin errors++; $display("FAIL mid_bclk_pre got %b want 1", bclk); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_ready_pre got %b want 0", ready); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
      checks++; if (ucount !== 16'd5) begin errors++; $display("FAIL mid_ucount_pre got %0d want 5", ucount); end
`endif
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (bclk !== 1'b0)     begin errors++; $display("FAIL mid_bclk got %b want 0", bclk); end
      checks++; if (lrclk !== 1'b0)    begin errors++; $display("FAIL mid_lrclk got %b want 0", lrclk); end
      checks++; if (din !== 1'b0)      begin errors++; $display("FAIL mid_din got %b want 0", din); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL mid_underrun got %b want 0", underrun); end
      checks++; if (ready !== 1'b1)    begin errors++; $display("FAIL mid_ready got %b want 1", ready); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
      checks++; if (ucount !== 16'd0)  begin errors++; $display("FAIL mid_ucount got %0d want 0", ucount); end
`endif
      reset = 1'b0;
      cyc   = 0;
      // Phase restarts and the held pair is gone: first wrap is an underrun.
      test_idle(frame + 8);
   endtask

   task automatic test_narrow();
      int   t, k;
      logic exp_din, exp_u;
      reset24 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset24 = 1'b0;
      t       = 0;
      l24     = 24'hA5A5A5;
      r24     = 24'h3C3C3D;
      valid24 = 1'b1;
      checks++; if (ready24 !== 1'b1) begin errors++; $display("FAIL n_ready_before got %b want 1", ready24); end
      while (t < 200) begin
         @(posedge clk);
         #1;
         t++;
         if (t == 1) begin
            valid24 = 1'b0;
            checks++; if (ready24 !== 1'b0) begin errors++; $display("FAIL n_ready_held got %b want 0", ready24); end
         end
         k = (t % 96) / 2;
         if (t < 96)       exp_din = 1'b0;
         else if (t < 192) exp_din = (k == 0) ? 1'b0 : (k <= 24) ? l24[24 - k] : r24[48 - k];
         else              exp_din = (k == 0) ? r24[0] : 1'b0;
         exp_u = (t == 192);
         checks++; if (bclk24 !== 1'(t % 2)) begin errors++; $display("FAIL n_bclk t=%0d got %b", t, bclk24); end
         checks++; if (lrclk24 !== 1'(k >= 24)) begin errors++; $display("FAIL n_lrclk t=%0d got %b want %b", t, lrclk24, k >= 24); end
         checks++; if (din24 !== exp_din) begin errors++; $display("FAIL n_din t=%0d k=%0d got %b want %b", t, k, din24, exp_din); end
         checks++; if (underrun24 !== exp_u) begin errors++; $display("FAIL n_underrun t=%0d got %b want %b", t, underrun24, exp_u); end
      end
   endtask

   initial begin
      reset   = 1'b1;
      reset24 = 1'b1;
      valid   = 1'b0;
      valid24 = 1'b0;
      pair    = '0;
      l24     = '0;
      r24     = '0;
      frame   = CLK_HZ / int'(fs_hz(CLK_HZ, DEF_BCLK_DIV, DEF_SLOT_WIDTH));
      test_narrow();
      test_reset();
      test_idle(1100);
      test_single_push();
      test_hold_valid();
      test_load_accept();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
